// File: rtl/dino_collision_detect.sv
// Dino-vs-danger collision detector: snapshots object state on each game tick and checks up to three danger slots in turn.
// Optional macro COLL_HIT_COUNT_EN adds a saturating hit_count output.
module dino_collision_detect #(
    parameter int GROUND         = 400,
    parameter int DINO_X         = 40,
    parameter int DINO_STAND_W   = 44,
    parameter int DINO_STAND_H   = 47,
    parameter int DINO_SIT_W     = 59,
    parameter int DINO_SIT_H     = 26,
    parameter int LOW_BIRD_LIFT  = 10,
    parameter int HIGH_BIRD_LIFT = 40,
    parameter int HIT_MARGIN     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_clk,
    input  logic [9:0] dino_pos,
    input  logic       dino_behavior,
    input  logic [9:0] danger_pos1,
    input  logic [9:0] danger_pos2,
    input  logic [9:0] danger_pos3,
    input  logic [2:0] danger_type1,
    input  logic [2:0] danger_type2,
    input  logic [2:0] danger_type3,
    input  logic       danger_en1,
    input  logic       danger_en2,
    input  logic       danger_en3,
    input  logic [1:0] game_state,
    output logic       isColision,
    output logic [1:0] hit_slot,
    output logic       busy
`ifdef COLL_HIT_COUNT_EN
    ,
    output logic [7:0] hit_count
`endif
);

    typedef enum logic [2:0] {IDLE, SNAP, CHK1, CHK2, CHK3, DONE} state_e;

    localparam logic [1:0] GS_INIT  = 2'd0;
    localparam logic [1:0] GS_START = 2'd1;
    localparam logic [1:0] GS_RESET = 2'd3;

    localparam logic signed [10:0] GND_S      = 11'(GROUND);
    localparam logic signed [10:0] DX_S       = 11'(DINO_X);
    localparam logic signed [10:0] M_S        = 11'(HIT_MARGIN);
    localparam logic signed [10:0] STAND_W_S  = 11'(DINO_STAND_W);
    localparam logic signed [10:0] STAND_H_S  = 11'(DINO_STAND_H);
    localparam logic signed [10:0] SIT_W_S    = 11'(DINO_SIT_W);
    localparam logic signed [10:0] SIT_H_S    = 11'(DINO_SIT_H);
    localparam logic signed [10:0] LOW_LIFT_S = 11'(LOW_BIRD_LIFT);
    localparam logic signed [10:0] HI_LIFT_S  = 11'(HIGH_BIRD_LIFT);

    function automatic logic signed [10:0] clamp0(input logic signed [10:0] v);
        return v[10] ? 11'sd0 : v;
    endfunction

    state_e      state, next_state;
    logic [2:0]  sync_q;
    logic        tick;
    logic [1:0]  found_q;
    logic        clear, set_now;

    logic [9:0]  dino_pos_q, pos1_q, pos2_q, pos3_q;
    logic [2:0]  type1_q, type2_q, type3_q;
    logic        beh_q, en1_q, en2_q, en3_q;
    logic [1:0]  gs_q;

    logic [9:0]  sel_pos;
    logic [2:0]  sel_type;
    logic        sel_en;
    logic [1:0]  sel_slot;
    logic signed [10:0] d_w, d_h, d_xlo, d_xhi, d_ylo, d_yhi, dpos_s;
    logic signed [10:0] o_w, o_h, o_bot, o_xlo, o_xhi, o_ylo, o_yhi, pos_s;
    logic        o_valid, hit_now;

    assign tick    = sync_q[1] & ~sync_q[2];
    assign clear   = (game_state == GS_RESET) || (game_state == GS_INIT);
    assign set_now = (state == DONE) && (gs_q == GS_START) && (found_q != 2'd0);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (tick) next_state = SNAP;
            SNAP:    next_state = CHK1;
            CHK1:    next_state = CHK2;
            CHK2:    next_state = CHK3;
            CHK3:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sel_pos  = pos1_q;
        sel_type = type1_q;
        sel_en   = en1_q;
        sel_slot = 2'd1;
        case (state)
            CHK2:    begin sel_pos = pos2_q; sel_type = type2_q; sel_en = en2_q; sel_slot = 2'd2; end
            CHK3:    begin sel_pos = pos3_q; sel_type = type3_q; sel_en = en3_q; sel_slot = 2'd3; end
            default: ;
        endcase

        d_w    = beh_q ? STAND_W_S : SIT_W_S;
        d_h    = beh_q ? STAND_H_S : SIT_H_S;
        dpos_s = $signed({1'b0, dino_pos_q});
        d_xlo  = DX_S + M_S;
        d_xhi  = DX_S + d_w - M_S;
        d_ylo  = clamp0(dpos_s - d_h + M_S);
        d_yhi  = clamp0(dpos_s - M_S);

        o_valid = 1'b1;
        o_w     = 11'sd0;
        o_h     = 11'sd0;
        o_bot   = GND_S;
        case (sel_type)
            3'd0:    begin o_w = 11'sd44; o_h = 11'sd33; o_bot = GND_S - LOW_LIFT_S; end
            3'd1:    begin o_w = 11'sd44; o_h = 11'sd33; o_bot = GND_S - HI_LIFT_S;  end
            3'd2:    begin o_w = 11'sd19; o_h = 11'sd36; end
            3'd3:    begin o_w = 11'sd77; o_h = 11'sd49; end
            3'd4:    begin o_w = 11'sd27; o_h = 11'sd50; end
            default: o_valid = 1'b0;
        endcase
        pos_s = $signed({1'b0, sel_pos});
        o_xlo = clamp0(pos_s - o_w);
        o_xhi = pos_s;
        o_yhi = clamp0(o_bot);
        o_ylo = clamp0(o_bot - o_h);

        // Strict overlap: boxes that only touch do not collide.
        hit_now = o_valid && sel_en
               && (d_xlo < o_xhi) && (o_xlo < d_xhi)
               && (d_ylo < o_yhi) && (o_ylo < d_yhi);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            sync_q     <= '0;
            found_q    <= '0;
            isColision <= 1'b0;
            hit_slot   <= '0;
        end else begin
            state  <= next_state;
            sync_q <= {sync_q[1:0], game_clk};
            if (state == SNAP)
                found_q <= '0;
            else if ((state == CHK1 || state == CHK2 || state == CHK3) && hit_now && found_q == 2'd0)
                found_q <= sel_slot;
            if (clear) begin
                isColision <= 1'b0;
                hit_slot   <= '0;
            end else if (set_now) begin
                isColision <= 1'b1;
                hit_slot   <= found_q;
            end
        end
    end

    // NOTE: the snapshot registers carry no reset; the FSM never reads them before SNAP loads them.
    always_ff @(posedge clk) begin
        if (state == SNAP) begin
            dino_pos_q <= dino_pos;
            beh_q      <= dino_behavior;
            pos1_q     <= danger_pos1;
            pos2_q     <= danger_pos2;
            pos3_q     <= danger_pos3;
            type1_q    <= danger_type1;
            type2_q    <= danger_type2;
            type3_q    <= danger_type3;
            en1_q      <= danger_en1;
            en2_q      <= danger_en2;
            en3_q      <= danger_en3;
            gs_q       <= game_state;
        end
    end

`ifdef COLL_HIT_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst)
            hit_count <= '0;
        else if (!clear && set_now && !isColision && hit_count != 8'hFF)
            hit_count <= hit_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_dino_collision_detect.sv
// Directed bench for dino_collision_detect: vector table plus multi-cycle corner sequences.
// Also covers hit_count when COLL_HIT_COUNT_EN is defined.
module tb_dino_collision_detect;

    logic       clk = 1'b0;
    logic       rst;
    logic       game_clk;
    logic [9:0] dino_pos;
    logic       dino_behavior;
    logic [9:0] danger_pos1, danger_pos2, danger_pos3;
    logic [2:0] danger_type1, danger_type2, danger_type3;
    logic       danger_en1, danger_en2, danger_en3;
    logic [1:0] game_state;
    logic       isColision;
    logic [1:0] hit_slot;
    logic       busy;
`ifdef COLL_HIT_COUNT_EN
    logic [7:0] hit_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dino_collision_detect dut (
        .clk(clk), .rst(rst), .game_clk(game_clk),
        .dino_pos(dino_pos), .dino_behavior(dino_behavior),
        .danger_pos1(danger_pos1), .danger_pos2(danger_pos2), .danger_pos3(danger_pos3),
        .danger_type1(danger_type1), .danger_type2(danger_type2), .danger_type3(danger_type3),
        .danger_en1(danger_en1), .danger_en2(danger_en2), .danger_en3(danger_en3),
        .game_state(game_state), .isColision(isColision), .hit_slot(hit_slot), .busy(busy)
`ifdef COLL_HIT_COUNT_EN
        , .hit_count(hit_count)
`endif
    );

    typedef struct {
        string name;
        int    dpos;
        bit    beh;
        int    pos1, pos2, pos3;
        int    typ1, typ2, typ3;
        bit    en1, en2, en3;
        int    gs;
        int    exp_col;
        int    exp_slot;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(string name, int dpos, bit beh,
                                int p1, int t1, bit e1, int p2, int t2, bit e2,
                                int p3, int t3, bit e3, int gs, int col, int slot);
        vec_t v;
        v.name = name; v.dpos = dpos; v.beh = beh;
        v.pos1 = p1; v.typ1 = t1; v.en1 = e1;
        v.pos2 = p2; v.typ2 = t2; v.en2 = e2;
        v.pos3 = p3; v.typ3 = t3; v.en3 = e3;
        v.gs = gs; v.exp_col = col; v.exp_slot = slot;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        dino_pos      = 10'(v.dpos);
        dino_behavior = v.beh;
        danger_pos1 = 10'(v.pos1); danger_type1 = 3'(v.typ1); danger_en1 = v.en1;
        danger_pos2 = 10'(v.pos2); danger_type2 = 3'(v.typ2); danger_en2 = v.en2;
        danger_pos3 = 10'(v.pos3); danger_type3 = 3'(v.typ3); danger_en3 = v.en3;
        game_state  = 2'(v.gs);
    endtask

    // One game_clk rise; the k-th negedge follows the k-th posedge after the rise.
    task automatic run_pass(input bit chk_busy);
        game_clk = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (chk_busy) check($sformatf("busy_k%0d", k), int'(busy), (k >= 3 && k <= 7) ? 1 : 0);
            if (k == 3) game_clk = 1'b0;
        end
    endtask

    task automatic game_reset();
        game_state = 2'd3;
        @(negedge clk);
    endtask

    initial begin
        // name, dino_pos, stand, slot1(pos,type,en), slot2, slot3, game_state, exp col, exp slot
        vecs[0]  = mk("stand_small_cactus", 400, 1, 70, 2, 1,  0, 5, 0,  0, 5, 0, 1, 1, 1);
        vecs[1]  = mk("jump_over_cactus",   300, 1, 70, 2, 1,  0, 5, 0,  0, 5, 0, 1, 0, 0);
        vecs[2]  = mk("sit_under_hbird",    400, 0,  0, 5, 0, 80, 1, 1,  0, 5, 0, 1, 0, 0);
        vecs[3]  = mk("stand_hbird",        400, 1,  0, 5, 0, 80, 1, 1,  0, 5, 0, 1, 1, 2);
        vecs[4]  = mk("disabled_and_none",  400, 1, 70, 2, 0,  0, 5, 0, 70, 5, 1, 1, 0, 0);
        vecs[5]  = mk("slot1_over_slot3",   400, 1, 70, 2, 1,  0, 5, 0, 75, 4, 1, 1, 1, 1);
        vecs[6]  = mk("x_touch",            400, 1, 42, 2, 1,  0, 5, 0,  0, 5, 0, 1, 0, 0);
        vecs[7]  = mk("x_one_px",           400, 1, 43, 2, 1,  0, 5, 0,  0, 5, 0, 1, 1, 1);
        vecs[8]  = mk("x_clamp_many",       400, 1,  0, 5, 0, 50, 3, 1,  0, 5, 0, 1, 1, 2);
        vecs[9]  = mk("hit_in_end_state",   400, 1, 70, 2, 1,  0, 5, 0,  0, 5, 0, 2, 0, 0);
        vecs[10] = mk("y_touch_lbird",      359, 1,  0, 5, 0,  0, 5, 0, 80, 0, 1, 1, 0, 0);
        vecs[11] = mk("y_one_px_lbird",     360, 1,  0, 5, 0,  0, 5, 0, 80, 0, 1, 1, 1, 3);
        vecs[12] = mk("sit_touch_hbird",    384, 0, 80, 1, 1,  0, 5, 0,  0, 5, 0, 1, 0, 0);
        vecs[13] = mk("sit_one_px_hbird",   383, 0, 80, 1, 1,  0, 5, 0,  0, 5, 0, 1, 1, 1);

        rst = 1'b0;
        game_clk = 1'b0;
        apply(vecs[0]);
        game_state = 2'd0;
        repeat (2) @(negedge clk);
        check("reset_col",  int'(isColision), 0);
        check("reset_slot", int'(hit_slot),   0);
        check("reset_busy", int'(busy),       0);
`ifdef COLL_HIT_COUNT_EN
        check("reset_count", int'(hit_count), 0);
`endif
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            game_reset();
            apply(vecs[i]);
            run_pass(i == 0);
            check({vecs[i].name, "_col"},  int'(isColision), vecs[i].exp_col);
            check({vecs[i].name, "_slot"}, int'(hit_slot),   vecs[i].exp_slot);
        end

        // Inputs changed after the snapshot must not affect the pass in flight.
        game_reset();
        apply(vecs[0]);
        game_clk = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) game_clk = 1'b0;
            if (k == 4) dino_pos = 10'd300;
        end
        check("snapshot_col",  int'(isColision), 1);
        check("snapshot_slot", int'(hit_slot),   1);

        // Sticky through END with a non-colliding scene, then cleared by RESET on the next edge.
        game_state = 2'd2;
        dino_pos   = 10'd300;
        for (int n = 0; n < 10; n++) begin
            run_pass(1'b0);
            check($sformatf("end_sticky_%0d", n), int'(isColision), 1);
        end
        game_state = 2'd3;
        @(negedge clk);
        check("reset_clear_col",  int'(isColision), 0);
        check("reset_clear_slot", int'(hit_slot),   0);

        // INIT clears as well.
        apply(vecs[3]);
        run_pass(1'b0);
        check("pre_init_slot", int'(hit_slot), 2);
        game_state = 2'd0;
        @(negedge clk);
        check("init_clear_col", int'(isColision), 0);

        // Live RESET during DONE beats the set.
        apply(vecs[0]);
        game_clk = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) game_clk = 1'b0;
            if (k == 7) game_state = 2'd3;
        end
        check("clear_prio_col",  int'(isColision), 0);
        check("clear_prio_slot", int'(hit_slot),   0);

        // A second tick arriving while busy is dropped.
        apply(vecs[0]);
        game_clk = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 3) game_clk = 1'b0;
            if (k == 4) game_clk = 1'b1;
            check($sformatf("drop_busy_k%0d", k), int'(busy), (k >= 3 && k <= 7) ? 1 : 0);
        end
        game_clk = 1'b0;
        repeat (3) @(negedge clk);
        check("drop_col", int'(isColision), 1);

        // rst during CHK2 aborts the pass and clears outputs on that edge.
        game_clk = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 3) game_clk = 1'b0;
        end
        check("pre_rst_busy", int'(busy), 1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", int'(busy),       0);
        check("rst_mid_col",  int'(isColision), 0);
        check("rst_mid_slot", int'(hit_slot),   0);
`ifdef COLL_HIT_COUNT_EN
        check("rst_mid_count", int'(hit_count), 0);
`endif
        rst = 1'b1;
        @(negedge clk);
        run_pass(1'b1);
        check("post_rst_col",  int'(isColision), 1);
        check("post_rst_slot", int'(hit_slot),   1);
`ifdef COLL_HIT_COUNT_EN
        check("count_first", int'(hit_count), 1);
        run_pass(1'b0);
        check("count_held_while_set", int'(hit_count), 1);
        game_reset();
        check("count_survives_game_reset", int'(hit_count), 1);
        game_state = 2'd1;
        run_pass(1'b0);
        check("count_second", int'(hit_count), 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dino_collision_detect.md
Name: dino_collision_detect

Overview:
Consumes the object controller's outputs (dino position and behaviour, three danger slots, game state) and produces the isColision input that drives the controller's GAME_END transition. On each game_clk tick it snapshots the object state. It then checks the dino hitbox against each enabled danger slot with a sequential bounding-box FSM. It keeps a sticky collision flag until the game resets.

Parameters:
GROUND, 400, dino bottom-edge y when standing on ground; cacti bottom-edge y
DINO_X, 40, dino left-edge x (fixed)
DINO_STAND_W, 44, standing dino width
DINO_STAND_H, 47, standing dino height
DINO_SIT_W, 59, sitting dino width
DINO_SIT_H, 26, sitting dino height
LOW_BIRD_LIFT, 10, low bird bottom edge = GROUND - lift
HIGH_BIRD_LIFT, 40, high bird bottom edge = GROUND - lift
HIT_MARGIN, 2, pixels trimmed from every side of the dino box

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
game_clk  in  1  game tick from the object controller; asynchronous to clk sampling
dino_pos  in  10  dino bottom-edge y
dino_behavior  in  1  0 = sit, 1 = stand
danger_pos1..3  in  10 each  danger right-edge x
danger_type1..3  in  3 each  0 low bird, 1 high bird, 2 small cactus, 3 many cactus, 4 big cactus, 5 nothing
danger_en1..3  in  1 each  slot valid
game_state  in  2  0 INIT, 1 START, 2 END, 3 RESET
isColision  out  1  sticky collision flag
hit_slot  out  2  slot of the first hit, 1..3; 0 = none
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst==0 at clk edge): isColision=0, hit_slot=0, busy=0, FSM=IDLE, synchroniser flops=0.
- game_clk passes through a 2-flop synchroniser plus a rising-edge detector, which gives a 1-cycle pulse tick at cycle T.
- FSM: IDLE -> SNAP -> CHK1 -> CHK2 -> CHK3 -> DONE -> IDLE, one clk per state.
- tick in IDLE moves the FSM to SNAP at T+1. A tick that arrives while busy is dropped.
- SNAP latches all object inputs and game_state. Later input changes do not affect the current pass.
- Dino box:
  - x range [DINO_X+M, DINO_X+W-M).
  - y range [dino_pos-H+M, dino_pos-M).
  - W and H are chosen by the latched dino_behavior; M = HIT_MARGIN.
- Danger box, slot i:
  - x range [max(pos-Wt, 0), pos).
  - Cactus y range [GROUND-Ht, GROUND).
  - Low bird y range [GROUND-LOW_BIRD_LIFT-33, GROUND-LOW_BIRD_LIFT).
  - High bird y range [GROUND-HIGH_BIRD_LIFT-33, GROUND-HIGH_BIRD_LIFT).
- Object sizes (w x h): small cactus 19x36, many cactus 77x49, big cactus 27x50, bird 44x33.
- All subtractions use 11-bit signed intermediates. x is clamped at 0; y underflow below 0 clamps to 0.
- Overlap is strict on both axes (a.lo < b.hi && b.lo < a.hi). Touching edges do not count as a hit.
- CHKi records a hit only when en_i==1, type_i!=5 and the boxes overlap. The first hit found, in slot order 1..3, is kept.
- DONE, cycle T+5, result registered at the edge ending DONE:
  - If latched game_state==START and a hit was found: isColision=1, and hit_slot = that slot.
  - Otherwise isColision and hit_slot hold their values.
- Clear: at any clk where live game_state is RESET or INIT, isColision=0 and hit_slot=0. Clear takes priority over a same-cycle DONE set.
- isColision stays 1 through game_state END until a clear.
- busy=1 in SNAP..DONE.
- rst mid-pass aborts the pass: FSM goes to IDLE and all outputs go to their reset values on that edge.

Optional Feature:
COLL_HIT_COUNT_EN
- Defined: adds output hit_count[7:0].
  - Increments by 1 on every 0->1 transition of isColision.
  - Saturates at 255.
  - Reset to 0 by rst only, not by game RESET.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Standing dino_pos=400, slot1 small cactus pos=70 en=1, game_state=1, one game_clk rise -> busy high T+1..T+5; isColision=1 and hit_slot=1 after DONE.
- Same setup but dino_pos=300 (jumping) -> isColision stays 0, hit_slot 0.
- Slot2 high bird pos=80, dino_pos=400 sitting -> 0; same with standing -> isColision=1, hit_slot=2.
- Slot1 overlapping cactus with en=0, plus slot3 type=5 en=1 overlapping -> isColision 0; then enable slot1 -> hit_slot=1 (first-slot priority when slots 1 and 3 both hit).
- After a hit, game_state=2 for 10 ticks -> isColision remains 1; game_state=3 -> isColision=0, hit_slot=0 on the next clk edge.
- rst=0 during CHK2 -> busy=0, isColision=0 on that edge; the next tick runs a full pass normally.
